// File: rtl/jam_cost_loader.sv
// rtl/jam_cost_loader.sv - loads an 8x8 cost table from a word stream and serves it to a JAM consumer
// Keeps a running total and per-worker minimum while loading.
module jam_cost_loader #(
  parameter int COST_W = 7
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  input  logic [COST_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  reload,
  input  logic [2:0]            W,
  input  logic [2:0]            J,
  output logic [COST_W-1:0]     Cost,
  output logic                  loaded,
  output logic                  load_done,
  output logic [8*COST_W-1:0]   row_min,
  output logic [COST_W+5:0]     total
);

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_SERVE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [5:0]          r_k;
  logic [COST_W-1:0]   r_table [64];
  logic [COST_W+5:0]   r_total;
  logic [COST_W-1:0]   r_row_min [8];
  logic                r_load_done;
  logic                w_xfer;
  logic                w_last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // reload and RST both suppress the transfer, so a dropped word never touches any state
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    loaded      = 1'b0;
    w_xfer      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        w_xfer   = in_valid && !reload && !RST;
        w_last   = w_xfer && (r_k == 6'd63);
        if (w_last) begin
          w_state_nxt = S_SERVE;
        end
      end
      S_SERVE: begin
        loaded = 1'b1;
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
    if (reload) begin
      w_state_nxt = S_LOAD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || reload) begin
      r_k         <= 6'd0;
      r_total     <= '0;
      r_load_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_row_min[i] <= '1;
      end
    end else begin
      r_load_done <= w_last;
      if (w_xfer) begin
        r_k     <= r_k + 6'd1;
        r_total <= r_total + {6'b0, in_data};
        if (in_data < r_row_min[r_k[5:3]]) begin
          r_row_min[r_k[5:3]] <= in_data;
        end
      end
    end
  end

  // Table storage has no reset; stale contents are hidden by gating Cost with loaded
  always_ff @(posedge CLK) begin
    if (w_xfer) begin
      r_table[r_k] <= in_data;
    end
  end

  assign Cost      = loaded ? r_table[{W, J}] : '0;
  assign load_done = r_load_done;
  assign total     = r_total;

  for (genvar g = 0; g < 8; g++) begin : g_row_min
    assign row_min[g*COST_W +: COST_W] = r_row_min[g];
  end

endmodule

// File: tb/tb_jam_cost_loader.sv
// tb/tb_jam_cost_loader.sv - self-checking bench for jam_cost_loader
// Model keeps the list of words accepted since the last reset/reload and derives outputs from it.
module tb_jam_cost_loader;

  localparam int CW = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [CW-1:0]   in_data;
  logic            in_ready;
  logic            reload;
  logic [2:0]      w_idx;
  logic [2:0]      j_idx;
  logic [CW-1:0]   cost;
  logic            loaded;
  logic            load_done;
  logic [8*CW-1:0] row_min;
  logic [CW+5:0]   total;

  int n_checks = 0;
  int n_errors = 0;

  jam_cost_loader #(.COST_W(CW)) dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .W(w_idx), .J(j_idx),
    .Cost(cost), .loaded(loaded), .load_done(load_done),
    .row_min(row_min), .total(total)
  );

  always #5 clk = ~clk;

  // behavioural model
  int          m_cnt = 0;
  int          m_tab [64];
  bit          m_loaded = 0;
  bit          m_ld = 0;
  bit          m_live = 0;

  always @(posedge clk) begin
    m_ld = 0;
    if (rst) begin
      m_live = 1; m_cnt = 0; m_loaded = 0;
    end else if (reload) begin
      m_cnt = 0; m_loaded = 0;
    end else if (!m_loaded && in_valid) begin
      m_tab[m_cnt] = int'(in_data);
      m_cnt++;
      if (m_cnt == 64) begin
        m_loaded = 1; m_ld = 1;
      end
    end
  end

  function automatic int exp_total();
    int s = 0;
    int n = m_loaded ? 64 : m_cnt;
    for (int i = 0; i < n; i++) s += m_tab[i];
    return s;
  endfunction

  function automatic logic [8*CW-1:0] exp_row_min();
    logic [8*CW-1:0] r;
    int n = m_loaded ? 64 : m_cnt;
    for (int w = 0; w < 8; w++) begin
      int mn = 127;
      for (int i = 0; i < n; i++)
        if (i / 8 == w && m_tab[i] < mn) mn = m_tab[i];
      r[w*CW +: CW] = CW'(mn);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 64'(in_ready), 64'(!m_loaded));
      chk("loaded", 64'(loaded), 64'(m_loaded));
      chk("load_done", 64'(load_done), 64'(m_ld));
      chk("total", 64'(total), 64'(exp_total()));
      chk("row_min", 64'(row_min), 64'(exp_row_min()));
      chk("cost", 64'(cost), m_loaded ? 64'(m_tab[{w_idx, j_idx}]) : 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit rl);
    in_valid = 1'b1; in_data = CW'(v); reload = rl;
    step();
    in_valid = 1'b0; reload = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  logic [8*CW-1:0] rm_ramp;
  logic [8*CW-1:0] rm_five;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; reload = 1'b0; w_idx = 3'd5; j_idx = 3'd3;
    for (int w = 0; w < 8; w++) begin
      rm_ramp[w*CW +: CW] = CW'(8 * w);
      rm_five[w*CW +: CW] = CW'(5);
    end
    step(); step();
    rst = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_total", 64'(total), 64'd0);
    chk("reset_row_min", 64'(row_min), {8'h0, {56{1'b1}}});

    // full back-to-back load
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_data = CW'(i);
      step();
    end
    in_valid = 1'b0;
    chk("full_load_done", 64'(load_done), 64'd1);
    chk("full_loaded", 64'(loaded), 64'd1);
    chk("full_total", 64'(total), 64'd2016);
    chk("full_row_min", 64'(row_min), 64'(rm_ramp));
    chk("full_cost_5_3", 64'(cost), 64'd43);
    step();
    chk("full_done_one_cycle", 64'(load_done), 64'd0);

    // gapped load
    pulse_reload();
    for (int i = 0; i < 64; i++) begin
      send(i, 1'b0);
      step();
    end
    w_idx = 3'd7; j_idx = 3'd7;
    #1;
    chk("gap_loaded", 64'(loaded), 64'd1);
    chk("gap_total", 64'(total), 64'd2016);
    chk("gap_cost_7_7", 64'(cost), 64'd63);

    // extra words past the end of the table
    pulse_reload();
    for (int i = 0; i < 70; i++) begin
      in_valid = 1'b1; in_data = (i < 64) ? CW'(i) : CW'(127);
      step();
    end
    in_valid = 1'b0;
    chk("extra_in_ready", 64'(in_ready), 64'd0);
    chk("extra_total", 64'(total), 64'd2016);
    chk("extra_row_min", 64'(row_min), 64'(rm_ramp));

    // reload mid-load
    pulse_reload();
    for (int i = 0; i < 20; i++) send(100 + i, 1'b0);
    pulse_reload();
    for (int i = 0; i < 63; i++) send(5, 1'b0);
    chk("midreload_no_early_done", 64'(load_done), 64'd0);
    send(5, 1'b0);
    chk("midreload_done", 64'(load_done), 64'd1);
    chk("midreload_total", 64'(total), 64'd320);
    chk("midreload_row_min", 64'(row_min), 64'(rm_five));

    // reload coinciding with the 64th word
    pulse_reload();
    for (int i = 0; i < 63; i++) send(i, 1'b0);
    send(63, 1'b1);
    chk("simul_load_done", 64'(load_done), 64'd0);
    chk("simul_loaded", 64'(loaded), 64'd0);
    chk("simul_total", 64'(total), 64'd0);
    for (int i = 0; i < 63; i++) send(2, 1'b0);
    chk("simul_k_zero_no_done", 64'(load_done), 64'd0);
    send(2, 1'b0);
    chk("simul_k_zero_done", 64'(load_done), 64'd1);
    chk("simul_total2", 64'(total), 64'd128);

    // reset while serving
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_serve_loaded", 64'(loaded), 64'd0);
    chk("rst_serve_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 64; k++) begin
      w_idx = 3'(k / 8); j_idx = 3'(k % 8);
      #1;
      chk("rst_serve_cost", 64'(cost), 64'd0);
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jam_cost_loader.md
JAM_COST_LOADER -- requirements
Module: jam_cost_loader

Interface
REQ-001 Parameter: COST_W, default 7, bit width of one cost entry; the table geometry is fixed at 8 workers x 8 jobs.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  upstream cost word present on in_data.
REQ-005 in_data  input  COST_W  cost word, row-major order (worker-major, job-minor).
REQ-006 in_ready  output  1  loader accepts a word this cycle.
REQ-007 reload  input  1  discard table contents and restart loading at entry 0.
REQ-008 W  input  3  worker index from the JAM consumer.
REQ-009 J  input  3  job index from the JAM consumer.
REQ-010 Cost  output  COST_W  table[W][J] for the consumer.
REQ-011 loaded  output  1  table complete; Cost is valid.
REQ-012 load_done  output  1  one-cycle pulse when entry 63 is written.
REQ-013 row_min  output  8*COST_W  per-worker minimum cost; worker w occupies bits [w*COST_W +: COST_W].
REQ-014 total  output  COST_W+6  sum of all 64 accepted entries.

Function
REQ-015 States: LOAD and SERVE; reset enters LOAD.
REQ-016 LOAD: in_ready=1; a transfer occurs when in_valid=1 and in_ready=1 at a rising edge.
REQ-017 A 6-bit write index k starts at 0; each transfer writes in_data to table[k[5:3]][k[2:0]] and increments k.
REQ-018 Transfer with k=63: the entry is written, load_done=1 the next cycle, state -> SERVE, and k wraps to 0.
REQ-019 SERVE: in_ready=0; in_valid is ignored and no table, sum or row_min update occurs.
REQ-020 Cost is combinational from W, J and the table, so it is valid in the same cycle W/J change; the consumer samples on the falling edge.
REQ-021 Cost=0 whenever loaded=0, regardless of W/J.
REQ-022 loaded=1 exactly while state is SERVE.
REQ-023 total is registered and accumulates each accepted word, zero-extended to COST_W+6 bits; it cannot overflow (64*(2^COST_W-1) fits).
REQ-024 row_min[w] initialises to all-ones; on each accepted word for row w, row_min[w] <= min(row_min[w], in_data).
REQ-025 Until row w has been fully loaded, row_min[w] reflects only the entries written so far.
REQ-026 reload=1 (either state): next cycle state=LOAD, k=0, total=0, all row_min all-ones, loaded=0, load_done=0.
REQ-027 reload=1 with in_valid=1 in the same cycle: reload wins and the word is dropped; in_ready is still 1 in LOAD, but no write occurs.
REQ-028 reload=1 in the cycle the k=63 transfer would occur: reload wins and load_done does not pulse.
REQ-029 in_valid=0 in LOAD: hold all state; gaps between words are unlimited.
REQ-030 Table contents are not cleared by reset or reload; they are unobservable because Cost is forced to 0 until the next full load.

Reset
REQ-031 After RST: state=LOAD, k=0, in_ready=1, loaded=0, load_done=0, Cost=0, total=0, all row_min all-ones.
REQ-032 RST mid-load or in SERVE behaves identically to REQ-031 and has priority over reload and in_valid.

Verification
REQ-033 Full load: 64 back-to-back words, value = 8*w+j -> load_done pulses one cycle after word 63; loaded=1; total=2016; row_min[w]=8*w; W=5,J=3 gives Cost=43 in the same cycle.
REQ-034 Gapped load: in_valid toggles 1/0 over 64 words -> load completes after 128 cycles with the same table; no entry is skipped or duplicated.
REQ-035 Extra words: in_valid held 1 for 70 cycles, words 64..69 = 127 -> in_ready=0 after load; total excludes 127s; row_min unchanged.
REQ-036 Reload mid-load: reload after 20 words, then 64 words of value 5 -> total=320; every row_min=5; no load_done before the 64th new word.
REQ-037 Simultaneous events: reload with the 64th word -> no load_done; loaded stays 0; k=0; total=0.
REQ-038 Reset in SERVE: RST asserted 1 cycle -> loaded=0, Cost=0 for every W/J, in_ready=1 on the next cycle.
